fetch_pc_unit: RTL

Instruction-fetch front end for the 5-stage MIPS pipeline. Owns the program counter, issues instruction-memory requests, and delivers `{instr, pc, pc+4}` to the IF/ID boundary. Consumes the EX-stage ALU's branch redirect (`change_pc`, target PC) and flushes any wrong-path fetch.

---
 rtl/fetch_pc_unit_pkg.sv | 17 +
 rtl/fetch_skid_buf.sv | 59 +++++
 rtl/fetch_pc_unit.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_pc_unit_pkg.sv
// Shared definitions for the instruction-fetch front end: default PC width
// and the fetch FSM state encodings. Optional feature macro used by the
// block: FETCH_MISALIGN_CHECK_EN.
`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif

package fetch_pc_unit_pkg;

  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t FETCH_IDLE = 2'd0;
  localparam fetch_state_t FETCH_REQ  = 2'd1;
  localparam fetch_state_t FETCH_WAIT = 2'd2;
  localparam fetch_state_t FETCH_DROP = 2'd3;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding buffer for {instr, pc}. Catches a fetch response that
// arrives while the IF/ID register is frozen by a stall. Flush wins over
// load, load wins over drain.
module fetch_skid_buf
  import fetch_pc_unit_pkg::*;
#(
  parameter int PC_WIDTH = 32,
  parameter int IWIDTH   = 32
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                flush_i,
  input  logic                load_i,
  input  logic                drain_i,
  input  logic [IWIDTH-1:0]   instr_i,
  input  logic [PC_WIDTH-1:0] pc_i,
  output logic                valid_o,
  output logic [IWIDTH-1:0]   instr_o,
  output logic [PC_WIDTH-1:0] pc_o
);

  logic                valid_q, valid_d;
  logic [IWIDTH-1:0]   instr_q, instr_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;

  // Next-state selection for the single entry.
  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      instr_d = instr_i;
      pc_d    = pc_i;
    end else if (drain_i) begin
      valid_d = 1'b0;
    end
  end

  // Entry storage with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch front end: owns the PC, keeps at most one imem request
// outstanding, and presents {instr, pc, pc+4} to IF/ID. An EX redirect
// withdraws pending work and drops any wrong-path response still in flight.
// Optional feature: define FETCH_MISALIGN_CHECK_EN to trap misaligned
// redirect targets instead of silently clearing the low address bits.
`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif

module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter int                  PC_WIDTH = `PC_WIDTH,
  parameter int                  IWIDTH   = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                f_i_clk,
  input  logic                f_i_rst_n,
  input  logic                f_i_change_pc,
  input  logic [PC_WIDTH-1:0] f_i_alu_pc,
  input  logic                f_i_stall,
  output logic                f_o_imem_req_valid,
  output logic [PC_WIDTH-1:0] f_o_imem_addr,
  input  logic                f_i_imem_req_ready,
  input  logic                f_i_imem_rsp_valid,
  input  logic [IWIDTH-1:0]   f_i_imem_rsp_data,
  output logic                f_o_valid,
  output logic [IWIDTH-1:0]   f_o_instr,
  output logic [PC_WIDTH-1:0] f_o_pc,
  output logic [PC_WIDTH-1:0] f_o_pc_plus4
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic                f_o_misalign
`endif
);

  localparam logic [PC_WIDTH-1:0] PC_STEP    = PC_WIDTH'(4);
  localparam logic [PC_WIDTH-1:0] ALIGN_MASK = ~PC_WIDTH'(3);

  fetch_state_t        state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d, pc_next;
  logic                out_valid_q, out_valid_d;
  logic [IWIDTH-1:0]   out_instr_q, out_instr_d;
  logic [PC_WIDTH-1:0] out_pc_q, out_pc_d;
  logic [PC_WIDTH-1:0] out_pc4_q, out_pc4_d;

  logic                hold, rsp_in_wait, issue, outstanding;
  logic                bad_target, misalign_flag;
  logic [PC_WIDTH-1:0] target;

  logic                skid_valid, skid_load, skid_drain;
  logic [IWIDTH-1:0]   skid_instr;
  logic [PC_WIDTH-1:0] skid_pc;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misalign_q, misalign_d;

  assign bad_target    = |f_i_alu_pc[1:0];
  assign target        = f_i_alu_pc;
  assign misalign_flag = misalign_q;
  assign f_o_misalign  = misalign_q;

  // Flag is (re)evaluated only on a redirect, so it sticks until the next one.
  always_comb begin
    misalign_d = misalign_q;
    if (f_i_change_pc) misalign_d = bad_target;
  end

  // Misalignment flag register.
  always_ff @(posedge f_i_clk) begin
    if (!f_i_rst_n) misalign_q <= 1'b0;
    else            misalign_q <= misalign_d;
  end
`else
  assign bad_target    = 1'b0;
  assign target        = f_i_alu_pc & ALIGN_MASK;
  assign misalign_flag = 1'b0;
`endif

  fetch_skid_buf #(
    .PC_WIDTH (PC_WIDTH),
    .IWIDTH   (IWIDTH)
  ) u_skid (
    .clk_i   (f_i_clk),
    .rst_n_i (f_i_rst_n),
    .flush_i (f_i_change_pc),
    .load_i  (skid_load),
    .drain_i (skid_drain),
    .instr_i (f_i_imem_rsp_data),
    .pc_i    (pc_q),
    .valid_o (skid_valid),
    .instr_o (skid_instr),
    .pc_o    (skid_pc)
  );

  // Request generation. In WAIT the next request is chained combinationally
  // off the response, so its address is already pc+4.
  always_comb begin
    hold        = f_i_stall & out_valid_q;
    pc_next     = pc_q + PC_STEP;
    rsp_in_wait = (state_q == FETCH_WAIT) & f_i_imem_rsp_valid;
    outstanding = ((state_q == FETCH_WAIT) | (state_q == FETCH_DROP)) & ~f_i_imem_rsp_valid;
    issue       = 1'b0;
    case (state_q)
      FETCH_REQ:  issue = ~skid_valid;
      FETCH_WAIT: issue = rsp_in_wait & ~hold & ~skid_valid;
      default:    issue = 1'b0;
    endcase
    issue              = issue & ~f_i_change_pc;
    f_o_imem_req_valid = issue;
    f_o_imem_addr      = (state_q == FETCH_WAIT) ? pc_next : pc_q;
  end

  // FSM, PC and IF/ID register next state; redirect overrides everything.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_pc_d    = out_pc_q;
    out_pc4_d   = out_pc4_q;
    skid_load   = 1'b0;
    skid_drain  = 1'b0;

    // Anything not held is taken by IF/ID this cycle.
    if (!hold) out_valid_d = 1'b0;

    if (skid_valid && !f_i_stall) begin
      out_valid_d = 1'b1;
      out_instr_d = skid_instr;
      out_pc_d    = skid_pc;
      out_pc4_d   = skid_pc + PC_STEP;
      skid_drain  = 1'b1;
    end

    case (state_q)
      FETCH_IDLE: if (!misalign_flag) state_d = FETCH_REQ;
      FETCH_REQ:  if (issue && f_i_imem_req_ready) state_d = FETCH_WAIT;
      FETCH_WAIT: begin
        if (rsp_in_wait) begin
          pc_d = pc_next;
          if (hold) begin
            skid_load = 1'b1;
          end else begin
            out_valid_d = 1'b1;
            out_instr_d = f_i_imem_rsp_data;
            out_pc_d    = pc_q;
            out_pc4_d   = pc_next;
          end
          state_d = (issue && f_i_imem_req_ready) ? FETCH_WAIT : FETCH_REQ;
        end
      end
      FETCH_DROP: if (f_i_imem_rsp_valid) state_d = misalign_flag ? FETCH_IDLE : FETCH_REQ;
      default:    state_d = FETCH_IDLE;
    endcase

    if (f_i_change_pc) begin
      pc_d        = target;
      out_valid_d = 1'b0;
      skid_load   = 1'b0;
      skid_drain  = 1'b0;
      // A wrong-path response still in flight must be swallowed first, even
      // for a trapped target; DROP then parks in IDLE while the flag is set.
      if (outstanding)     state_d = FETCH_DROP;
      else if (bad_target) state_d = FETCH_IDLE;
      else                 state_d = FETCH_REQ;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge f_i_clk) begin
    if (!f_i_rst_n) begin
      state_q     <= FETCH_IDLE;
      pc_q        <= RESET_PC;
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_pc_q    <= '0;
      out_pc4_q   <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_pc_q    <= out_pc_d;
      out_pc4_q   <= out_pc4_d;
    end
  end

  assign f_o_valid    = out_valid_q;
  assign f_o_instr    = out_instr_q;
  assign f_o_pc       = out_pc_q;
  assign f_o_pc_plus4 = out_pc4_q;

endmodule
